uart_tx: RTL

//   UART transmitter; pairs with uart_rx on the same link (8N1 default, LSB first, idle high).

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_tx_if.sv
// Byte-producer to UART transmitter link: start/ready handshake, done pulse and serial line.
interface uart_tx_if;
  logic [7:0] data_tx;
  logic       start_tx;
  logic       ready_tx;
  logic       done_tx;
  logic       tx;

  modport master (output data_tx, output start_tx, input ready_tx, input done_tx, input tx);
  modport slave  (input data_tx, input start_tx, output ready_tx, output done_tx, output tx);
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter, LSB first, idle-high line, 1 or 2 stop bits, integer baud divider.
module uart_tx #(
  parameter int CLK_FREQ  = 200_000_000,
  parameter int BAUDRATE  = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int DIV = CLK_FREQ / BAUDRATE;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_chk
      $error("uart_tx: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic last_cnt;
  logic frame_end;
  logic accept;

  assign last_cnt  = (cnt_q == CNT_LAST);
  assign frame_end = (state_q == S_STOP) && last_cnt && (stop_q == STOP_LAST);
  // Ready/done are raised in the final stop-bit cycle so a held start_tx is taken
  // on the frame-end edge itself, giving zero idle cycles between frames.
  assign accept = bus.start_tx && bus.ready_tx;

  assign bus.ready_tx = (state_q == S_IDLE) || frame_end;
  assign bus.done_tx  = frame_end;
  assign bus.tx       = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    if (state_q != S_IDLE) begin
      cnt_d = last_cnt ? '0 : cnt_q + CNT_ONE;
    end
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          shift_d = bus.data_tx;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (last_cnt) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (last_cnt) begin
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      default: begin
        if (last_cnt) begin
          if (stop_q == STOP_LAST) begin
            if (accept) begin
              state_d = S_START;
              shift_d = bus.data_tx;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      stop_q  <= 1'b0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end
endmodule
